memory_arbiter: RTL and testbench

Shares the single external memory port between the instruction fetch requester and the data requester. The data requester is the write buffer fed by the decode stage's load/store/fence path. Each requester posts a one-cycle request pulse, which the arbiter latches as pending. The arbiter grants one transaction at a time, with data priority and a starvation guard for instruction fetch, and returns a one-cycle ready pulse with read data to the granted requester. It sits between the fetch/writebuffer units and the memory/bus interface.

---
 rtl/memory_arbiter.sv | 153 +++++++++++++++
 tb/tb_memory_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Shares one external memory port between instruction fetch and the data write buffer.
// Data requests have priority, but instruction fetch is granted after MAX_DATA_GRANTS
// consecutive data grants so it cannot starve. Every output is registered.
module memory_arbiter #(
  parameter int unsigned MAX_DATA_GRANTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  input  logic        dmem_valid,
  input  logic        dmem_fence,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MaxGrants = 4'(MAX_DATA_GRANTS);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e      state_q;
  logic        i_pend_q;
  logic [31:0] i_addr_q;
  logic        d_pend_q;
  logic        d_fence_q;
  logic [31:0] d_addr_q;
  logic [31:0] d_wdata_q;
  logic [3:0]  d_wstrb_q;
  logic [3:0]  starve_cnt_q;

  logic grant_i;
  logic grant_d;
  logic complete;

  // Arbitration decision in IDLE; completion ignores mem_ready in the issue cycle.
  always_comb begin
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    complete = 1'b0;
    if (state_q == StIdle) begin
      if (i_pend_q && (!d_pend_q || starve_cnt_q == MaxGrants)) begin
        grant_i = 1'b1;
      end else if (d_pend_q) begin
        grant_d = 1'b1;
      end
    end else begin
      complete = mem_ready && !mem_valid;
    end
  end

  // Request capture, grant FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      i_pend_q     <= 1'b0;
      i_addr_q     <= '0;
      d_pend_q     <= 1'b0;
      d_fence_q    <= 1'b0;
      d_addr_q     <= '0;
      d_wdata_q    <= '0;
      d_wstrb_q    <= '0;
      starve_cnt_q <= '0;
      imem_ready   <= 1'b0;
      imem_rdata   <= '0;
      dmem_ready   <= 1'b0;
      dmem_rdata   <= '0;
      mem_valid    <= 1'b0;
      mem_instr    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
    end else begin
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;
      mem_valid  <= 1'b0;

      // A valid while the same requester is still pending is dropped.
      if (imem_valid && !i_pend_q) begin
        i_pend_q <= 1'b1;
        i_addr_q <= imem_addr;
      end
      if (dmem_valid && !d_pend_q) begin
        d_pend_q  <= 1'b1;
        d_fence_q <= dmem_fence;
        d_addr_q  <= dmem_addr;
        d_wdata_q <= dmem_wdata;
        d_wstrb_q <= dmem_wstrb;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_i) begin
            i_pend_q     <= 1'b0;
            starve_cnt_q <= '0;
            state_q      <= StBusyI;
            mem_valid    <= 1'b1;
            mem_instr    <= 1'b1;
            mem_addr     <= i_addr_q;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
          end else if (grant_d) begin
            d_pend_q <= 1'b0;
            if (!i_pend_q) begin
              starve_cnt_q <= '0;
            end else if (starve_cnt_q != MaxGrants) begin
              starve_cnt_q <= starve_cnt_q + 4'd1;
            end
            if (d_fence_q) begin
              // Fence completes locally without touching memory.
              dmem_ready <= 1'b1;
              dmem_rdata <= '0;
            end else begin
              state_q   <= StBusyD;
              mem_valid <= 1'b1;
              mem_instr <= 1'b0;
              mem_addr  <= d_addr_q;
              mem_wdata <= d_wdata_q;
              mem_wstrb <= d_wstrb_q;
            end
          end
        end
        StBusyI: begin
          if (complete) begin
            imem_ready <= 1'b1;
            imem_rdata <= mem_rdata;
            state_q    <= StIdle;
          end
        end
        StBusyD: begin
          if (complete) begin
            dmem_ready <= 1'b1;
            dmem_rdata <= mem_rdata;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter checked every cycle against a queue-based model.
module tb_memory_arbiter;

  localparam int unsigned MaxGrants = 4;
  localparam int          NumCycles = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_valid;
  logic        dmem_fence;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  memory_arbiter #(.MAX_DATA_GRANTS(MaxGrants)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_valid (dmem_valid),
    .dmem_fence (dmem_fence),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  // Reference model: pending requests as queues, the granted requester, and the run
  // length of data grants taken while a fetch was waiting.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        fence;
  } dreq_t;

  logic [31:0] iq[$];
  dreq_t       dq[$];
  int          owner;   // 0 none, 1 fetch, 2 data
  int          streak;
  logic        e_iready, e_dready, e_mvalid, e_minstr;
  logic [31:0] e_irdata, e_drdata, e_maddr, e_mwdata;
  logic [3:0]  e_mwstrb;

  task automatic model_edge();
    bit    had_i, had_d, issued_now;
    dreq_t r;
    if (rst) begin
      iq.delete(); dq.delete();
      owner = 0; streak = 0;
      e_iready = 0; e_dready = 0; e_mvalid = 0; e_minstr = 0;
      e_irdata = 0; e_drdata = 0; e_maddr = 0; e_mwdata = 0; e_mwstrb = 0;
      return;
    end
    had_i = iq.size() != 0;
    had_d = dq.size() != 0;
    issued_now = e_mvalid;
    e_iready = 0; e_dready = 0; e_mvalid = 0;
    if (owner == 0) begin
      if (had_i && (!had_d || streak == MaxGrants)) begin
        e_mvalid = 1; e_minstr = 1; e_maddr = iq.pop_front(); e_mwdata = 0; e_mwstrb = 0;
        streak = 0; owner = 1;
      end else if (had_d) begin
        r = dq.pop_front();
        streak = had_i ? ((streak < MaxGrants) ? streak + 1 : streak) : 0;
        if (r.fence) begin
          e_dready = 1; e_drdata = 0;
        end else begin
          e_mvalid = 1; e_minstr = 0; e_maddr = r.addr; e_mwdata = r.wdata; e_mwstrb = r.wstrb;
          owner = 2;
        end
      end
    end else if (mem_ready && !issued_now) begin
      if (owner == 1) begin e_iready = 1; e_irdata = mem_rdata; end
      else begin e_dready = 1; e_drdata = mem_rdata; end
      owner = 0;
    end
    if (imem_valid && !had_i) iq.push_back(imem_addr);
    if (dmem_valid && !had_d) begin
      r.addr = dmem_addr; r.wdata = dmem_wdata; r.wstrb = dmem_wstrb; r.fence = dmem_fence;
      dq.push_back(r);
    end
  endtask

  // Bench-side requester and memory responder state.
  bit i_out, d_out, resp_pend;
  int resp_cnt;

  initial begin
    rst = 1; imem_valid = 0; imem_addr = 0; dmem_valid = 0; dmem_fence = 0;
    dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0; mem_ready = 0; mem_rdata = 0;
    i_out = 0; d_out = 0; resp_pend = 0; resp_cnt = 0;
    for (int k = 0; k < NumCycles; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      cyc = k;
      check_val("imem_ready", 32'(imem_ready), 32'(e_iready));
      check_val("dmem_ready", 32'(dmem_ready), 32'(e_dready));
      check_val("mem_valid", 32'(mem_valid), 32'(e_mvalid));
      check_val("mem_instr", 32'(mem_instr), 32'(e_minstr));
      check_val("mem_addr", mem_addr, e_maddr);
      check_val("mem_wdata", mem_wdata, e_mwdata);
      check_val("mem_wstrb", 32'(mem_wstrb), 32'(e_mwstrb));
      check_val("imem_rdata", imem_rdata, e_irdata);
      check_val("dmem_rdata", dmem_rdata, e_drdata);

      // Single fetch of 0x100 requested in cycle 1, answered two cycles after issue.
      if (k == 0) check_val("reset_mem_valid", 32'(mem_valid), 32'd0);
      if (k == 3) begin
        check_val("fetch_issue", {mem_valid, mem_instr}, 32'd3);
        check_val("fetch_addr", mem_addr, 32'h100);
      end
      if (k == 6) begin
        check_val("fetch_ready", {imem_ready, dmem_ready}, 32'd2);
        check_val("fetch_rdata", imem_rdata, 32'h13);
      end

      if (imem_ready) i_out = 0;
      if (dmem_ready) d_out = 0;

      // Memory responder: a stale response survives reset on purpose.
      mem_ready = 0;
      if (resp_pend) begin
        if (resp_cnt == 0) begin
          mem_ready = 1;
          mem_rdata = (k < 10) ? 32'h13 : $urandom;
          resp_pend = 0;
        end else begin
          resp_cnt--;
        end
      end else if (k >= 10 && $urandom_range(0, 7) == 0) begin
        mem_ready = 1;
        mem_rdata = $urandom;
      end
      if (mem_valid) begin
        resp_pend = 1;
        resp_cnt  = (k < 10) ? 1 : int'($urandom_range(0, 2));
      end

      // Requesters: at most one outstanding each, occasional reset.
      imem_valid = 0;
      dmem_valid = 0;
      rst = (k >= 10) && ($urandom_range(0, 149) == 0);
      if (rst) begin
        i_out = 0;
        d_out = 0;
      end else if (k == 1) begin
        imem_valid = 1; imem_addr = 32'h100; i_out = 1;
      end else if (k >= 10) begin
        if (!i_out && $urandom_range(0, 3) == 0) begin
          imem_valid = 1; imem_addr = $urandom; i_out = 1;
        end
        if (!d_out && $urandom_range(0, 2) != 0) begin
          dmem_valid = 1;
          dmem_fence = ($urandom_range(0, 5) == 0);
          dmem_addr  = $urandom;
          dmem_wdata = $urandom;
          dmem_wstrb = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
          d_out = 1;
        end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
